// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem access at a time and
// hands each fetched word with its PC to decode over a valid/ready handshake.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    // Handshake: a word transfers to decode on a rising clk edge where
    // instr_valid && instr_ready; instr_valid never waits on instr_ready.
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic [31:0] instr_data_q, instr_data_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] redirect_pc_al;

    assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc_al;
                end
                // A grant alongside a redirect still launches the old PC; mark it stale.
                if (imem_gnt) begin
                    state_d = WAIT;
                    drop_d  = redirect_valid;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d   = redirect_pc_al;
                    drop_d = 1'b1;
                end
                if (imem_rvalid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_data_d = imem_rdata;
                        instr_pc_d   = pc_q;
                        pc_d         = pc_q + 32'd4;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    state_d = REQ;
                end
                if (redirect_valid) begin
                    pc_d    = redirect_pc_al;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            instr_data_q <= 32'h0;
            instr_pc_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: imem responses are produced by a small
// one-outstanding memory model driven cycle by cycle from the test tasks.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int          total;
    int          bad;
    logic        pend;
    logic [31:0] pend_addr;

    fetch_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // Drive one cycle from a negedge to the next: g offers a grant, rv lets a
    // pending response return, rdy is decode ready, rd/rpc a redirect pulse.
    task automatic tick(input bit g, input bit rv, input bit rdy, input bit rd,
                        input logic [31:0] rpc);
        logic        np;
        logic [31:0] na;
        imem_gnt       = g;
        imem_rvalid    = pend && rv;
        imem_rdata     = (pend && rv) ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        instr_ready    = rdy;
        redirect_valid = rd;
        redirect_pc    = rd ? rpc : 32'hFFFF_FFFF;
        if (g && imem_req) begin
            np = 1'b1;
            na = imem_addr;
        end else begin
            np = pend && !rv;
            na = pend_addr;
        end
        @(posedge clk);
        @(negedge clk);
        pend      = np;
        pend_addr = na;
    endtask

    // From REQ: grant then respond, leaving the DUT in HOLD.
    task automatic run_to_hold();
        tick(1, 1, 0, 0, 32'h0);
        tick(1, 1, 0, 0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        pend = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 32'h0);
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req cyc=%0d got=%b exp=0", i, imem_req); end
        end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL reset_addr got=%h exp=00000100", imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        total++; if (instr_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", instr_data); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
        rst = 1'b1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        tick(0, 0, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] exp_pc;
        for (int c = 0; c < 9; c++) begin
            total++; if (imem_req !== 1'((c % 3) == 0)) begin bad++; $display("FAIL basic_req cyc=%0d got=%b", c, imem_req); end
            total++; if (instr_valid !== 1'((c % 3) == 2)) begin bad++; $display("FAIL basic_valid cyc=%0d got=%b", c, instr_valid); end
            if ((c % 3) == 2) begin
                exp_pc = 32'h100 + 32'(4 * (c / 3));
                total++; if (instr_pc !== exp_pc) begin bad++; $display("FAIL basic_pc got=%h exp=%h", instr_pc, exp_pc); end
                total++; if (instr_data !== mem_word(exp_pc)) begin bad++; $display("FAIL basic_data got=%h exp=%h", instr_data, mem_word(exp_pc)); end
            end
            tick(1, 1, 1, 0, 32'h0);
        end
    endtask

    task automatic test_backpressure();
        run_to_hold();
        for (int i = 0; i < 5; i++) begin
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, instr_valid); end
            total++; if (instr_pc !== 32'h10C) begin bad++; $display("FAIL bp_pc got=%h exp=0000010c", instr_pc); end
            total++; if (instr_data !== mem_word(32'h10C)) begin bad++; $display("FAIL bp_data got=%h exp=%h", instr_data, mem_word(32'h10C)); end
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req got=%b exp=0", imem_req); end
            tick(1, 1, 0, 0, 32'h0);
        end
        tick(1, 1, 1, 0, 32'h0);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h110) begin bad++; $display("FAIL bp_resume req=%b addr=%h exp=1/00000110", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        tick(1, 1, 0, 0, 32'h0);
        tick(0, 0, 0, 1, 32'h2000);
        total++; if (imem_addr !== 32'h2000 || imem_req !== 1'b0) begin bad++; $display("FAIL rw_wait addr=%h req=%b exp=00002000/0", imem_addr, imem_req); end
        tick(0, 1, 1, 0, 32'h0);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rw_dropped valid=%b exp=0", instr_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin bad++; $display("FAIL rw_refetch req=%b addr=%h exp=1/00002000", imem_req, imem_addr); end
        run_to_hold();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2000) begin bad++; $display("FAIL rw_pc valid=%b pc=%h exp=1/00002000", instr_valid, instr_pc); end
        total++; if (instr_data !== mem_word(32'h2000)) begin bad++; $display("FAIL rw_data got=%h exp=%h", instr_data, mem_word(32'h2000)); end
        tick(0, 0, 1, 0, 32'h0);
    endtask

    task automatic test_redirect_with_gnt();
        tick(1, 1, 0, 1, 32'h3000);
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h3000) begin bad++; $display("FAIL rg_wait req=%b addr=%h exp=0/00003000", imem_req, imem_addr); end
        tick(0, 1, 0, 0, 32'h0);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rg_dropped valid=%b exp=0", instr_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin bad++; $display("FAIL rg_refetch req=%b addr=%h exp=1/00003000", imem_req, imem_addr); end
        run_to_hold();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h3000) begin bad++; $display("FAIL rg_pc valid=%b pc=%h exp=1/00003000", instr_valid, instr_pc); end
        tick(0, 0, 1, 0, 32'h0);
    endtask

    task automatic test_redirect_with_rvalid();
        tick(1, 1, 0, 0, 32'h0);
        tick(0, 1, 0, 1, 32'h4000);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rr_dropped valid=%b exp=0", instr_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4000) begin bad++; $display("FAIL rr_refetch req=%b addr=%h exp=1/00004000", imem_req, imem_addr); end
        run_to_hold();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4000) begin bad++; $display("FAIL rr_pc valid=%b pc=%h exp=1/00004000", instr_valid, instr_pc); end
    endtask

    task automatic test_redirect_handshake();
        tick(0, 0, 1, 1, 32'h5000);
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rh_valid got=%b exp=0", instr_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h5000) begin bad++; $display("FAIL rh_target req=%b addr=%h exp=1/00005000", imem_req, imem_addr); end
        run_to_hold();
        total++; if (instr_pc !== 32'h5000 || instr_data !== mem_word(32'h5000)) begin bad++; $display("FAIL rh_fetch pc=%h data=%h exp=00005000/%h", instr_pc, instr_data, mem_word(32'h5000)); end
        tick(0, 0, 0, 1, 32'h5100);
        total++; if (instr_valid !== 1'b0 || imem_addr !== 32'h5100) begin bad++; $display("FAIL rh_noready valid=%b addr=%h exp=0/00005100", instr_valid, imem_addr); end
    endtask

    task automatic test_wrap_align();
        tick(0, 0, 0, 1, 32'hFFFF_FFFC);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wa_redirect req=%b addr=%h exp=1/fffffffc", imem_req, imem_addr); end
        run_to_hold();
        total++; if (instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wa_pc got=%h exp=fffffffc", instr_pc); end
        tick(0, 0, 1, 0, 32'h0);
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wa_wrap got=%h exp=00000000", imem_addr); end
        tick(0, 0, 0, 1, 32'h0000_1003);
        total++; if (imem_addr !== 32'h1000) begin bad++; $display("FAIL wa_align got=%h exp=00001000", imem_addr); end
    endtask

    task automatic test_slow_grant_and_reset();
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 32'h0);
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin bad++; $display("FAIL sg_hold cyc=%0d req=%b addr=%h exp=1/00001000", i, imem_req, imem_addr); end
        end
        tick(1, 1, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL sg_wait req=%b exp=0", imem_req); end
        rst = 1'b0;
        tick(0, 0, 0, 0, 32'h0);
        pend = 1'b0;
        total++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin bad++; $display("FAIL mr_req req=%b addr=%h exp=0/00000100", imem_req, imem_addr); end
        total++; if (instr_valid !== 1'b0 || instr_data !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL mr_out valid=%b data=%h pc=%h exp=0/0/0", instr_valid, instr_data, instr_pc); end
        rst = 1'b1;
        tick(0, 0, 0, 0, 32'h0);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL mr_restart req=%b addr=%h exp=1/00000100", imem_req, imem_addr); end
        run_to_hold();
        total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin bad++; $display("FAIL mr_fetch valid=%b pc=%h exp=1/00000100", instr_valid, instr_pc); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        pend = 1'b0;
        pend_addr = 32'h0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_with_gnt();
        test_redirect_with_rvalid();
        test_redirect_handshake();
        test_wrap_align();
        test_slow_grant_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction memory through a request/grant/response handshake. It keeps at most one outstanding memory access and delivers each fetched word, with its PC, to decode over a valid/ready handshake. A branch or jump redirect from execute replaces the PC at any time and discards a fetch already in flight. It sits between the PC/imem pair and the decode stage, replacing free-running PC update in the pipelined core.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- clk  input  1  rising-edge clock.
- rst  input  1  reset. Synchronous, active-low: sampled on clk, and state resets when rst=0.
- imem_req  output  1  fetch request to imem.
- imem_addr  output  32  fetch address; equals the current PC.
- imem_gnt  input  1  imem accepts the request in a cycle where imem_req=1.
- imem_rvalid  input  1  response valid; at earliest the cycle after gnt.
- imem_rdata  input  32  instruction word; valid when imem_rvalid=1.
- redirect_valid  input  1  single-cycle pulse requesting a PC change.
- redirect_pc  input  32  new PC; bits [1:0] are ignored and treated as 0.
- instr_valid  output  1  instr_data and instr_pc hold a fetched instruction.
- instr_ready  input  1  decode accepts the instruction.
- instr_data  output  32  fetched instruction.
- instr_pc  output  32  PC of instr_data.

## Operation
- Registers:
  - pc[31:0]
  - state: IDLE, REQ, WAIT or HOLD
  - drop flag
  - output registers instr_data and instr_pc
- imem_req=1 only in REQ. imem_addr=pc in every state.
- IDLE (reset state): go to REQ unconditionally on the next cycle.
- REQ:
  - redirect_valid=1 and imem_gnt=0: pc<=redirect_pc, stay in REQ.
  - imem_gnt=1 and no redirect: go to WAIT.
  - imem_gnt=1 and redirect_valid=1 in the same cycle: the request is accepted for the old pc; pc<=redirect_pc, drop<=1, go to WAIT.
- WAIT:
  - redirect_valid=1: pc<=redirect_pc, drop<=1.
  - imem_rvalid=1 with drop=1, or with redirect_valid=1 in the same cycle: discard the data, drop<=0, go to REQ.
  - imem_rvalid=1 otherwise: instr_data<=imem_rdata, instr_pc<=pc, pc<=pc+4, go to HOLD.
- HOLD:
  - instr_valid=1 only in HOLD.
  - instr_valid && instr_ready: handshake completes; go to REQ.
  - redirect_valid=1: pc<=redirect_pc, go to REQ (instr_valid drops the next cycle).
  - Redirect in the same cycle as a handshake: the handshake counts (decode consumed the word), and the redirect is still applied.
- PC arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. pc[1:0] is always 0.
- Drop is cleared only by a dropped response or by reset. No second request is issued while drop=1 (the FSM stays in WAIT).
- While in HOLD, instr_data and instr_pc remain stable until the handshake or redirect.

## Timing
- Reset (rst=0 at a clk edge):
  - state=IDLE, pc=RESET_PC, drop=0
  - imem_req=0, imem_addr=RESET_PC
  - instr_valid=0, instr_data=0, instr_pc=0
  - Reset mid-transaction abandons any outstanding response. imem must also be reset.
- Cycle after reset release: IDLE. The next cycle is REQ with imem_req=1.
- Latency: with gnt in the REQ cycle (cycle n) and rvalid in cycle n+1, instr_valid=1 in cycle n+2.
- Peak throughput with ready tied high: one instruction per 3 cycles (REQ, WAIT, HOLD).
- No combinational path from any input to imem_req, instr_valid, instr_data or instr_pc; all four are decoded from registers.
- redirect_pc is sampled only in the cycle redirect_valid=1.

## Test plan
- **Reset/basic fetch:** RESET_PC=0x100; gnt is immediate and rvalid has 1-cycle latency; ready=1.
  - Required: instr_pc sequence 0x100, 0x104, 0x108, with instr_valid pulsing every 3rd cycle.
  - Required: imem_req=0 while rst=0.
- **Backpressure:** instr_ready=0 for 5 cycles while instr_valid=1.
  - Required: instr_data, instr_pc and instr_valid stay stable.
  - Required: no imem_req until the handshake, then fetch resumes at pc+4.
- **Redirect during WAIT:** redirect to 0x2000 one cycle before rvalid.
  - Required: the response is dropped and instr_valid is never raised for the old PC.
  - Required: the next imem_addr is 0x2000, and the next instr_pc is 0x2000.
- **Simultaneous events:**
  - Redirect in the same cycle as gnt in REQ: the in-flight response is dropped.
  - Redirect in the same cycle as rvalid: the response is dropped.
  - Redirect in the same cycle as a HOLD handshake: the word is consumed, and the next fetch is at the redirect target.
- **Wrap and alignment:**
  - pc=0xFFFF_FFFC is followed by pc=0x0000_0000.
  - redirect_pc=0x0000_1003 produces imem_addr=0x0000_1000.
- **Slow grant and reset mid-operation:**
  - Hold gnt low for 4 cycles: imem_req stays 1 with a stable imem_addr.
  - Assert rst=0 during WAIT: the next cycle shows all outputs at their reset values, and fetch restarts at RESET_PC.
